video_timing_gen: RTL and testbench

- Parametrised, runtime-reconfigurable raster timing generator; next generation of the fixed-mode video block.
- Produces hsync/vsync/DE, visible-area coordinates, and a flashing-field mask with measurement start trigger, all aligned at a configurable pipeline depth.
- Sits between the mode/config decoder and pixel/overlay logic, which consumes visible_x/visible_y and field_hit.

---
 rtl/video_timing_pkg.sv | 23 ++
 rtl/delayline.sv | 35 +++
 rtl/video_timing_gen.sv | 228 ++++++++++++++++++++++
 tb/tb_video_timing_gen.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared definitions for the video timing generator.
// - Field indices used to unpack the 4-field h/v timing buses and the
//   {start, end} geometry pairs.
// - Half-open range compare used by the flash-field hit logic.
package video_timing_pkg;

  // Field positions inside {sync, back_porch, active, front_porch}, index 0 in the LSBs.
  localparam int unsigned FldFp     = 0;
  localparam int unsigned FldActive = 1;
  localparam int unsigned FldBp     = 2;
  localparam int unsigned FldSync   = 3;

  // Field positions inside a {start, end} geometry pair.
  localparam int unsigned GeoEnd   = 0;
  localparam int unsigned GeoStart = 1;

  // True when lo <= v < hi; lo >= hi yields an empty range.
  function automatic logic in_range(input logic [31:0] v, input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/delayline.sv
// Fixed-length register delay line with asynchronous active-high clear.
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset, clears every stage
//   d_i    - data in
//   q_o    - data in delayed by CYCLES clocks
// CYCLES must be at least 1; callers bypass the instance for zero delay.
module delayline #(
  parameter int unsigned CYCLES = 1,
  parameter int unsigned WIDTH  = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [CYCLES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < CYCLES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < CYCLES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[CYCLES-1];

endmodule

// File: rtl/video_timing_gen.sv
// Runtime-reconfigurable raster timing generator.
// Produces sync/DE, visible-area coordinates and a flashing field mask, all
// aligned to PIPE_DELAY+1 clocks after the raster counters.
// Ports:
//   clock, reset         - pixel clock, asynchronous active-high reset
//   h_timing, v_timing   - {sync, back_porch, active, front_porch}, MSB first
//   sync_pol             - {h_pol, v_pol}, asserted sync level
//   field_x              - {x_start, x_end}, shared by all fields, end exclusive
//   field_y              - {y_start, y_end} per field, field 0 in the LSBs
//   frame_period         - frames per flash half-period, 0 disables flashing (live)
//   mode_load            - pulse: capture timing/geometry into the shadow set
//   hsync, vsync, de     - raster outputs
//   visible_x, visible_y - coordinates relative to the active origin
//   field_hit            - per-field hit, qualified by de and flash_on
//   flash_on             - current flash state
//   starttrigger         - first active pixel of a frame where flash_on rises
//   frame_start          - first active pixel of every frame
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned W          = 12,
  parameter int unsigned PIPE_DELAY = 2,
  parameter int unsigned NUM_FIELDS = 3,
  parameter int unsigned FP_W       = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [4*W-1:0]            h_timing,
  input  logic [4*W-1:0]            v_timing,
  input  logic [1:0]                sync_pol,
  input  logic [2*W-1:0]            field_x,
  input  logic [2*W*NUM_FIELDS-1:0] field_y,
  input  logic [FP_W-1:0]           frame_period,
  input  logic                      mode_load,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      de,
  output logic [W-1:0]              visible_x,
  output logic [W-1:0]              visible_y,
  output logic [NUM_FIELDS-1:0]     field_hit,
  output logic                      flash_on,
  output logic                      starttrigger,
  output logic                      frame_start
);

  // Totals and counters carry two extra bits so a sum of four W-bit fields never truncates.
  localparam int unsigned TW   = W + 2;
  localparam int unsigned FyW  = 2 * W * NUM_FIELDS;
  localparam int unsigned CfgW = 8 * W + 2 + 2 * W + FyW;
  localparam int unsigned DlW  = 5 + 2 * W + NUM_FIELDS + 1;

  // Configuration: shadow captures on mode_load, active is what the raster runs on.
  logic [CfgW-1:0] cfg_in;
  logic [CfgW-1:0] shadow_q, shadow_d;
  logic [CfgW-1:0] active_q, active_d;
  logic            pending_q, pending_d;
  // First cycle after reset release loads the inputs straight into the active set.
  logic            init_q;

  logic [TW-1:0]   cx_q, cx_d;
  logic [TW-1:0]   cy_q, cy_d;
  logic [FP_W-1:0] fc_q, fc_d;
  logic            flash_q, flash_d;

  assign cfg_in = {h_timing, v_timing, sync_pol, field_x, field_y};

  logic [4*W-1:0] h_act, v_act;
  logic [1:0]     pol_act;
  logic [2*W-1:0] fx_act;
  logic [FyW-1:0] fy_act;

  assign {h_act, v_act, pol_act, fx_act, fy_act} = active_q;

  // Timing boundaries derived from the active set.
  logic [TW-1:0] h_sync_w, h_start, h_end, h_total;
  logic [TW-1:0] v_sync_w, v_start, v_end, v_total;

  always_comb begin
    h_sync_w = TW'(h_act[FldSync*W +: W]);
    h_start  = h_sync_w + TW'(h_act[FldBp*W +: W]);
    h_end    = h_start + TW'(h_act[FldActive*W +: W]);
    h_total  = h_end + TW'(h_act[FldFp*W +: W]);
    v_sync_w = TW'(v_act[FldSync*W +: W]);
    v_start  = v_sync_w + TW'(v_act[FldBp*W +: W]);
    v_end    = v_start + TW'(v_act[FldActive*W +: W]);
    v_total  = v_end + TW'(v_act[FldFp*W +: W]);
  end

  logic line_end, frame_end;

  assign line_end  = (cx_q == h_total - 1'b1);
  assign frame_end = line_end && (cy_q == v_total - 1'b1);

  // Counters and configuration transfer.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    if (init_q) begin
      shadow_d  = cfg_in;
      active_d  = cfg_in;
      pending_d = 1'b0;
    end else begin
      if (mode_load) begin
        shadow_d  = cfg_in;
        pending_d = 1'b1;
      end
      if (line_end) begin
        cx_d = '0;
        cy_d = frame_end ? '0 : cy_q + 1'b1;
        // A load landing on the boundary itself refreshes the shadow and waits a frame.
        if (frame_end && pending_q && !mode_load) begin
          active_d  = shadow_q;
          pending_d = 1'b0;
        end
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end
  end

  // Raster decode of the current counter position.
  logic          hs_c, vs_c, x_in, y_in, de_c, first_pix;
  logic [W-1:0]  vis_x_c, vis_y_c;

  always_comb begin
    hs_c      = (cx_q < h_sync_w) ? pol_act[1] : ~pol_act[1];
    vs_c      = (cy_q < v_sync_w) ? pol_act[0] : ~pol_act[0];
    x_in      = (cx_q >= h_start) && (cx_q < h_end);
    y_in      = (cy_q >= v_start) && (cy_q < v_end);
    de_c      = x_in && y_in;
    first_pix = de_c && (cx_q == h_start) && (cy_q == v_start);
    vis_x_c   = W'(cx_q - h_start);
    vis_y_c   = W'(cy_q - v_start);
  end

  // Flash state advances at the first active pixel; the updated value covers that whole frame.
  logic trig_c;

  always_comb begin
    fc_d    = fc_q;
    flash_d = flash_q;
    trig_c  = 1'b0;
    if (frame_period == '0) begin
      fc_d    = '0;
      flash_d = 1'b0;
    end else if (first_pix && !init_q) begin
      // >= also recovers when the period shrinks below the running count.
      if (fc_q >= frame_period - 1'b1) begin
        fc_d    = '0;
        flash_d = ~flash_q;
        trig_c  = ~flash_q;
      end else begin
        fc_d = fc_q + 1'b1;
      end
    end
  end

  logic [W-1:0]          x_lo, x_hi;
  logic [NUM_FIELDS-1:0] fh_c;

  assign x_lo = fx_act[GeoStart*W +: W];
  assign x_hi = fx_act[GeoEnd*W +: W];

  always_comb begin
    fh_c = '0;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      fh_c[k] = de_c & flash_d
              & in_range(32'(vis_x_c), 32'(x_lo), 32'(x_hi))
              & in_range(32'(vis_y_c), 32'(fy_act[2*W*k + GeoStart*W +: W]),
                         32'(fy_act[2*W*k + GeoEnd*W +: W]));
    end
  end

  // Stage 0 output register; held at zero while the active set is being loaded.
  logic [DlW-1:0] s0_d, s0_q, pipe_out;

  always_comb begin
    s0_d = '0;
    if (!init_q) begin
      s0_d = {hs_c, vs_c, de_c, trig_c, first_pix, vis_x_c, vis_y_c, fh_c, flash_d};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      init_q    <= 1'b1;
      pending_q <= 1'b1;
      shadow_q  <= '0;
      active_q  <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      fc_q      <= '0;
      flash_q   <= 1'b0;
      s0_q      <= '0;
    end else begin
      init_q    <= 1'b0;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      fc_q      <= fc_d;
      flash_q   <= flash_d;
      s0_q      <= s0_d;
    end
  end

  if (PIPE_DELAY == 0) begin : g_bypass
    assign pipe_out = s0_q;
  end else begin : g_delay
    delayline #(
      .CYCLES(PIPE_DELAY),
      .WIDTH (DlW)
    ) u_delayline (
      .clk_i(clock),
      .rst_i(reset),
      .d_i  (s0_q),
      .q_o  (pipe_out)
    );
  end

  assign {hsync, vsync, de, starttrigger, frame_start,
          visible_x, visible_y, field_hit, flash_on} = pipe_out;

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

  localparam int unsigned W  = 12;
  localparam int unsigned NF = 3;
  localparam int unsigned FP = 8;

  logic              clock;
  logic              reset;
  logic [4*W-1:0]    h_timing;
  logic [4*W-1:0]    v_timing;
  logic [1:0]        sync_pol;
  logic [2*W-1:0]    field_x;
  logic [2*W*NF-1:0] field_y;
  logic [FP-1:0]     frame_period;
  logic              mode_load;
  logic              hsync, vsync, de, flash_on, starttrigger, frame_start;
  logic [W-1:0]      visible_x, visible_y;
  logic [NF-1:0]     field_hit;

  int checks   = 0;
  int failures = 0;
  int edges;

  localparam logic [4*W-1:0] HMode8  = {12'd2, 12'd2, 12'd8, 12'd2};
  localparam logic [4*W-1:0] HMode10 = {12'd2, 12'd2, 12'd10, 12'd2};
  localparam logic [4*W-1:0] VMode   = {12'd1, 12'd1, 12'd4, 12'd1};

  video_timing_gen #(
    .W         (W),
    .PIPE_DELAY(2),
    .NUM_FIELDS(NF),
    .FP_W      (FP)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .h_timing    (h_timing),
    .v_timing    (v_timing),
    .sync_pol    (sync_pol),
    .field_x     (field_x),
    .field_y     (field_y),
    .frame_period(frame_period),
    .mode_load   (mode_load),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .visible_x   (visible_x),
    .visible_y   (visible_y),
    .field_hit   (field_hit),
    .flash_on    (flash_on),
    .starttrigger(starttrigger),
    .frame_start (frame_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Clock edges since the last reset release.
  always @(posedge clock or posedge reset) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic at_edge(input int k);
    while (edges < k) begin
      @(posedge clock);
      #1;
    end
  endtask

  // First frame after a reset release, mode h=2,2,8,2 v=1,1,4,1: pin at edge k shows
  // counter index k-4, 14 clocks per line, 98 per frame.
  task automatic frame0_checks(input string pfx);
    int n_de, n_hs, n_vs, n_fs, n_st, first_de;
    n_de = 0; n_hs = 0; n_vs = 0; n_fs = 0; n_st = 0; first_de = -1;
    at_edge(3);
    check({pfx, "_pipe_fill_hsync"}, 64'(hsync), 64'd0);
    at_edge(4);
    check({pfx, "_idx0_hsync"}, 64'(hsync), 64'd1);
    check({pfx, "_idx0_vsync"}, 64'(vsync), 64'd1);
    check({pfx, "_idx0_de"}, 64'(de), 64'd0);
    check({pfx, "_idx0_visx"}, 64'(visible_x), 64'hFFC);
    check({pfx, "_idx0_visy"}, 64'(visible_y), 64'hFFE);
    for (int k = 4; k <= 101; k++) begin
      at_edge(k);
      n_de += int'(de);
      n_hs += int'(hsync);
      n_vs += int'(vsync);
      n_fs += int'(frame_start);
      n_st += int'(starttrigger);
      if (de && first_de < 0) begin
        first_de = k;
        check({pfx, "_first_de_visx"}, 64'(visible_x), 64'd0);
        check({pfx, "_first_de_visy"}, 64'(visible_y), 64'd0);
        check({pfx, "_first_de_fs"}, 64'(frame_start), 64'd1);
      end
    end
    check({pfx, "_de_count"}, 64'(n_de), 64'd32);
    check({pfx, "_hsync_count"}, 64'(n_hs), 64'd14);
    check({pfx, "_vsync_count"}, 64'(n_vs), 64'd14);
    check({pfx, "_fs_count"}, 64'(n_fs), 64'd1);
    check({pfx, "_st_count"}, 64'(n_st), 64'd0);
    check({pfx, "_first_de_edge"}, 64'(first_de), 64'd36);
  endtask

  int n_de, n_hs, n_fs, n_st, n_sync, n_fh0, n_fh1, n_fh2, n_fl, n_fh;
  int st_edge, first_de, first_fs, rise1, rise2;
  logic prev_hs;

  initial begin
    reset        = 1'b1;
    h_timing     = HMode8;
    v_timing     = VMode;
    sync_pol     = 2'b11;
    field_x      = {12'd1, 12'd3};
    field_y      = {12'd3, 12'd3, 12'd2, 12'd3, 12'd0, 12'd1};
    frame_period = 8'd2;
    mode_load    = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs_zero",
          {31'd0, hsync, vsync, de, starttrigger, frame_start, flash_on, field_hit,
           visible_x, visible_y}, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    frame0_checks("pwr");

    // Frame 1: flash_on rises, so the trigger lines up with frame_start and the first de.
    at_edge(134);
    check("f1_first_pixel_fs_st_flash_de",
          64'({frame_start, starttrigger, flash_on, de}), 64'hF);
    check("f1_hit_0_0", 64'(field_hit), 64'd0);
    at_edge(135);
    check("f1_hit_1_0", 64'(field_hit), 64'd1);
    check("f1_st_one_cycle", 64'(starttrigger), 64'd0);
    at_edge(136);
    check("f1_hit_2_0", 64'(field_hit), 64'd1);
    at_edge(137);
    check("f1_hit_3_0", 64'(field_hit), 64'd0);
    at_edge(163);
    check("f1_hit_1_2", 64'(field_hit), 64'd2);
    at_edge(177);
    check("f1_hit_1_3_empty_field", 64'(field_hit), 64'd0);

    // Frames 2..5: flash on in 2 and 5, off in 3 and 4; one trigger in frame 5.
    n_fs = 0; n_st = 0; n_sync = 0; n_fh0 = 0; n_fh1 = 0; n_fh2 = 0; st_edge = -1;
    for (int k = 200; k <= 591; k++) begin
      at_edge(k);
      n_fs  += int'(frame_start);
      n_st  += int'(starttrigger);
      n_sync += int'(starttrigger && frame_start && de);
      n_fh0 += int'(field_hit[0]);
      n_fh1 += int'(field_hit[1]);
      n_fh2 += int'(field_hit[2]);
      if (starttrigger && st_edge < 0) st_edge = k;
    end
    check("f2_5_fs_count", 64'(n_fs), 64'd4);
    check("f2_5_st_count", 64'(n_st), 64'd1);
    check("f2_5_st_with_fs_de", 64'(n_sync), 64'd1);
    check("f2_5_st_edge", 64'(st_edge), 64'd526);
    check("f2_5_fh0_count", 64'(n_fh0), 64'd4);
    check("f2_5_fh1_count", 64'(n_fh1), 64'd4);
    check("f2_5_fh2_count", 64'(n_fh2), 64'd0);

    // Frame 6: load h_active=10 mid-frame; this frame keeps the old timing.
    n_de = 0; n_hs = 0;
    for (int k = 592; k <= 689; k++) begin
      at_edge(k);
      n_de += int'(de);
      n_hs += int'(hsync);
      if (k == 620) begin
        h_timing  = HMode10;
        mode_load = 1'b1;
      end
      if (k == 621) mode_load = 1'b0;
    end
    check("f6_de_count_unchanged", 64'(n_de), 64'd32);
    check("f6_hsync_count", 64'(n_hs), 64'd14);
    // Flash is on here; disabling must force it low.
    frame_period = 8'd0;

    // Frame 7: 16 clocks per line, 112 per frame.
    n_de = 0; n_hs = 0; first_de = -1; rise1 = -1; rise2 = -1;
    prev_hs = hsync;
    for (int k = 690; k <= 801; k++) begin
      at_edge(k);
      n_de += int'(de);
      n_hs += int'(hsync);
      if (hsync && !prev_hs) begin
        if (rise1 < 0) rise1 = k;
        else if (rise2 < 0) rise2 = k;
      end
      prev_hs = hsync;
      if (de && first_de < 0) begin
        first_de = k;
        check("f7_first_de_visx", 64'(visible_x), 64'd0);
      end
    end
    check("f7_de_count", 64'(n_de), 64'd40);
    check("f7_hsync_count", 64'(n_hs), 64'd14);
    check("f7_first_de_edge", 64'(first_de), 64'd726);
    check("f7_line_period", 64'(rise2 - rise1), 64'd16);

    // Frames 8..17 with flashing disabled.
    n_fs = 0; n_st = 0; n_fl = 0; n_fh = 0; first_fs = -1;
    for (int k = 802; k <= 1921; k++) begin
      at_edge(k);
      n_fs += int'(frame_start);
      n_st += int'(starttrigger);
      n_fl += int'(flash_on);
      n_fh += int'(field_hit != '0);
      if (frame_start && first_fs < 0) first_fs = k;
    end
    check("fp0_fs_count", 64'(n_fs), 64'd10);
    check("fp0_first_fs_edge", 64'(first_fs), 64'd838);
    check("fp0_flash_count", 64'(n_fl), 64'd0);
    check("fp0_st_count", 64'(n_st), 64'd0);
    check("fp0_fh_count", 64'(n_fh), 64'd0);

    // Frame 18: counters at cx=7,cy=3 after edge 1974; pins show cx=4,cy=3.
    at_edge(1974);
    check("prerst_de", 64'(de), 64'd1);
    check("prerst_visy", 64'(visible_y), 64'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("midframe_reset_outputs_zero",
          {31'd0, hsync, vsync, de, starttrigger, frame_start, flash_on, field_hit,
           visible_x, visible_y}, 64'd0);
    h_timing     = HMode8;
    frame_period = 8'd2;
    @(negedge clock);
    reset = 1'b0;

    frame0_checks("rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
